if_id_queue: RTL and testbench

- Decoupling buffer between the fetch stage and the decode stage.
- Captures (pc, instr) pairs from fetch in a small in-order FIFO and presents the oldest one to decode under a valid/ready handshake.
- Absorbs decode back-pressure so that fetch stalls are derived from a registered `in_ready` only.
- Flush discards every queued instruction on a taken branch or jump redirect.

---
 rtl/if_id_queue.sv | 97 +++++++++
 tb/tb_if_id_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling FIFO: one-cycle latency from accept to head, no in->out bypass.
// in_ready is purely registered (count < DEPTH); flush empties the queue and drops a same-cycle push.
module if_id_queue #(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_pc,
  input  logic [WIDTH-1:0]             in_instr,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_pc,
  output logic [WIDTH-1:0]             out_instr,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] pc_q    [DEPTH];
  logic [WIDTH-1:0] instr_q [DEPTH];

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign occupancy = count_q;
  assign out_pc    = out_valid ? pc_q[rd_q]    : '0;
  assign out_instr = out_valid ? instr_q[rd_q] : NOP_INSTR;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      pc_q[wr_q]    <= in_pc;
      instr_q[wr_q] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= DEPTH_C);
      assert (((int'(wr_q) - int'(rd_q) + DEPTH) % DEPTH) == (int'(count_q) % DEPTH));
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboarded bench: a DEPTH=2 and a DEPTH=3 instance, directed stimulus, per-DUT pop monitors.
module tb_if_id_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  ent_t exp_a[$];
  ent_t exp_b[$];
  ent_t ea;
  ent_t eb;

  // DEPTH=2 instance
  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [31:0] a_in_pc = '0, a_in_instr = '0;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_pc, a_out_instr;
  logic [1:0]  a_occ;

  // DEPTH=3 instance
  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [31:0] b_in_pc = '0, b_in_instr = '0;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_pc, b_out_instr;
  logic [1:0]  b_occ;

  if_id_queue #(.WIDTH(32), .DEPTH(2), .NOP_INSTR(32'h0000_0013)) u_dut2 (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_pc(a_in_pc), .in_instr(a_in_instr), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_pc(a_out_pc), .out_instr(a_out_instr), .out_ready(a_out_ready),
    .occupancy(a_occ)
  );

  if_id_queue #(.WIDTH(32), .DEPTH(3), .NOP_INSTR(32'h0000_0013)) u_dut3 (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_pc(b_in_pc), .in_instr(b_in_instr), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_pc(b_out_pc), .out_instr(b_out_instr), .out_ready(b_out_ready),
    .occupancy(b_occ)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h1300_0000 | pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [31:0] pc);
    a_in_valid = v;
    a_in_pc    = pc;
    a_in_instr = instr_of(pc);
  endtask

  task automatic a_expect(input logic [31:0] pc, input logic [31:0] instr);
    ent_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_a.push_back(e);
  endtask

  // Monitors: compare the head against the scoreboard whenever decode takes it.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) begin
        errs++;
        checks++;
        $display("FAIL a_unexpected_pop: got pc %h expected none", a_out_pc);
      end else begin
        ea = exp_a.pop_front();
        chk("a_head_pc", a_out_pc, ea.pc);
        chk("a_head_instr", a_out_instr, ea.instr);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) begin
        errs++;
        checks++;
        $display("FAIL b_unexpected_pop: got pc %h expected none", b_out_pc);
      end else begin
        eb = exp_b.pop_front();
        chk("b_head_pc", b_out_pc, eb.pc);
        chk("b_head_instr", b_out_instr, eb.instr);
      end
    end
  end

  // DEPTH=3 vectors: in_valid, pc, out_ready, occupancy after the edge.
  logic        b_iv  [17] = '{1,1,1,1,1,1,1,0,1,1,1,1,1,1,0,0,0};
  logic [31:0] b_pc  [17] = '{32'h00,32'h04,32'h08,32'h0C,32'h0C,32'h0C,32'h10,32'h00,
                              32'h14,32'h18,32'h1C,32'h20,32'h24,32'h28,32'h00,32'h00,32'h00};
  logic        b_rdy [17] = '{0,0,0,0,1,1,1,1,0,1,1,1,1,1,1,1,1};
  logic [1:0]  b_occ_exp [17] = '{1,2,3,3,2,2,2,1,2,2,2,2,2,2,1,0,0};

  initial begin
    ent_t e;

    // Reset with in_valid asserted: nothing may be captured.
    rst = 1'b1;
    a_drive(1'b1, 32'h100);
    tick();
    tick();
    chk("rst_in_ready", {31'b0, a_in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_out_instr", a_out_instr, 32'h0000_0013);
    chk("rst_out_pc", a_out_pc, 32'h0);
    chk("rst_occ", {30'b0, a_occ}, 32'd0);
    chk("rst3_occ", {30'b0, b_occ}, 32'd0);
    rst = 1'b0;
    a_drive(1'b0, 32'h0);
    tick();
    chk("post_rst_out_valid", {31'b0, a_out_valid}, 32'd0);

    // Single pass.
    a_in_valid = 1'b1;
    a_in_pc    = 32'h0;
    a_in_instr = 32'h0050_0093;
    a_expect(32'h0, 32'h0050_0093);
    tick();
    a_in_valid = 1'b0;
    chk("single_out_valid", {31'b0, a_out_valid}, 32'd1);
    chk("single_out_pc", a_out_pc, 32'h0);
    chk("single_out_instr", a_out_instr, 32'h0050_0093);
    chk("single_occ", {30'b0, a_occ}, 32'd1);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("single_drain_valid", {31'b0, a_out_valid}, 32'd0);
    chk("single_drain_nop", a_out_instr, 32'h0000_0013);
    chk("single_drain_occ", {30'b0, a_occ}, 32'd0);

    // Back-pressure: third push refused until decode drains.
    a_expect(32'h0, instr_of(32'h0));
    a_expect(32'h4, instr_of(32'h4));
    a_expect(32'h8, instr_of(32'h8));
    a_drive(1'b1, 32'h0);
    tick();
    chk("bp_rdy1", {31'b0, a_in_ready}, 32'd1);
    a_drive(1'b1, 32'h4);
    tick();
    chk("bp_rdy2", {31'b0, a_in_ready}, 32'd0);
    chk("bp_occ2", {30'b0, a_occ}, 32'd2);
    a_drive(1'b1, 32'h8);
    tick();
    chk("bp_full_occ", {30'b0, a_occ}, 32'd2);
    chk("bp_full_head", a_out_pc, 32'h0);
    a_out_ready = 1'b1;
    tick();
    chk("bp_rel_occ", {30'b0, a_occ}, 32'd1);
    chk("bp_rel_head", a_out_pc, 32'h4);
    chk("bp_rel_rdy", {31'b0, a_in_ready}, 32'd1);
    tick();
    a_drive(1'b0, 32'h0);
    chk("bp_acc_occ", {30'b0, a_occ}, 32'd1);
    chk("bp_acc_head", a_out_pc, 32'h8);
    tick();
    a_out_ready = 1'b0;
    chk("bp_end_occ", {30'b0, a_occ}, 32'd0);

    // Streaming: push and pop every cycle, pointers wrap repeatedly.
    a_out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a_drive(1'b1, 32'(4 * k));
      a_expect(32'(4 * k), instr_of(32'(4 * k)));
      tick();
      chk("stream_occ", {30'b0, a_occ}, 32'd1);
      chk("stream_head", a_out_pc, 32'(4 * k));
    end
    a_drive(1'b0, 32'h0);
    tick();
    a_out_ready = 1'b0;
    chk("stream_end_occ", {30'b0, a_occ}, 32'd0);

    // Flush with a concurrent push: everything dropped, 0x40 never appears.
    a_drive(1'b1, 32'h100);
    tick();
    a_drive(1'b1, 32'h104);
    tick();
    chk("flush_pre_occ", {30'b0, a_occ}, 32'd2);
    a_flush = 1'b1;
    a_drive(1'b1, 32'h40);
    tick();
    a_flush = 1'b0;
    a_drive(1'b0, 32'h0);
    chk("flush_occ", {30'b0, a_occ}, 32'd0);
    chk("flush_valid", {31'b0, a_out_valid}, 32'd0);
    chk("flush_rdy", {31'b0, a_in_ready}, 32'd1);
    a_drive(1'b1, 32'h80);
    a_expect(32'h80, instr_of(32'h80));
    tick();
    a_drive(1'b0, 32'h0);
    chk("flush_next_head", a_out_pc, 32'h80);
    chk("flush_next_occ", {30'b0, a_occ}, 32'd1);
    a_out_ready = 1'b1;
    tick();
    chk("flush_drain_occ", {30'b0, a_occ}, 32'd0);
    tick();
    a_out_ready = 1'b0;
    chk("empty_pop_occ", {30'b0, a_occ}, 32'd0);
    chk("empty_pop_valid", {31'b0, a_out_valid}, 32'd0);

    // DEPTH=3: partial fills and push/pop pairs across the non-power-of-two wrap.
    for (int p = 0; p <= 32'h28; p += 4) begin
      e.pc    = 32'(p);
      e.instr = instr_of(32'(p));
      exp_b.push_back(e);
    end
    for (int s = 0; s < 17; s++) begin
      b_in_valid  = b_iv[s];
      b_in_pc     = b_pc[s];
      b_in_instr  = instr_of(b_pc[s]);
      b_out_ready = b_rdy[s];
      tick();
      chk("d3_occ", {30'b0, b_occ}, {30'b0, b_occ_exp[s]});
      chk("d3_in_ready", {31'b0, b_in_ready}, (b_occ_exp[s] == 2'd3) ? 32'd0 : 32'd1);
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    tick();

    chk("a_drain", 32'(exp_a.size()), 32'd0);
    chk("b_drain", 32'(exp_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
